// File: rtl/fetch_if.sv
// Fetch-stage bus: memory address/data, decode handshake, redirect and status.
interface fetch_if;
    logic       start;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready;
    logic       redirect;
    logic [7:0] redirect_addr;
    logic       halted;

    modport master (
        input  start,
        output mem_addr,
        input  mem_data,
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready,
        input  redirect,
        input  redirect_addr,
        output halted
    );

    modport slave (
        output start,
        input  mem_addr,
        output mem_data,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready,
        output redirect,
        output redirect_addr,
        input  halted
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, captures memory bytes into a 2-entry
// prefetch FIFO and hands them to decode; supports redirect/flush and halt.
module fetch_unit #(
    parameter logic [7:0] START_ADDR  = 8'h00,
    parameter logic [7:0] HALT_OPCODE = 8'hFF,
    parameter bit         HALT_ENABLE = 1'b1
) (
    input  logic    clk,
    input  logic    reset,
    fetch_if.master bus
);

    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [DW-1:0]   data_q [DEPTH];
    logic [DW-1:0]   data_d [DEPTH];
    logic [AW-1:0]   bpc_q  [DEPTH];
    logic [AW-1:0]   bpc_d  [DEPTH];
    logic            valid_q, valid_d;
    logic            halted_q, halted_d;

    logic            pop_c;
    logic            push_c;
    logic            wr_idx_c;

    assign pop_c  = valid_q & bus.instr_ready;
    assign push_c = (state_q == FETCH) && ((count_q < CW'(DEPTH)) || pop_c);
    // Tail slot after this cycle's pop has been applied
    assign wr_idx_c = (count_q == CW'(2)) || ((count_q == CW'(1)) && !pop_c);

    // Next-state, PC and FIFO update
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        count_d  = count_q;
        data_d   = data_q;
        bpc_d    = bpc_q;

        if (bus.redirect && (state_q != IDLE)) begin
            // Flush: entries keep their contents so head outputs hold
            state_d = FETCH;
            pc_d    = bus.redirect_addr;
            count_d = '0;
        end else begin
            if ((state_q == IDLE) && bus.start) begin
                state_d = FETCH;
                pc_d    = START_ADDR;
            end

            // Shift only when a second entry exists, so an emptied FIFO
            // still presents the byte that was popped last
            if (pop_c && (count_q == CW'(2))) begin
                data_d[0] = data_q[1];
                bpc_d[0]  = bpc_q[1];
            end

            if (push_c) begin
                data_d[wr_idx_c] = bus.mem_data;
                bpc_d[wr_idx_c]  = pc_q;
                pc_d             = AW'(pc_q + AW'(1));
                if (HALT_ENABLE && (bus.mem_data == HALT_OPCODE)) begin
                    state_d = HALT;
                end
            end

            count_d = CW'(count_q - CW'(pop_c) + CW'(push_c));
        end

        valid_d  = (count_d != '0);
        halted_d = (state_d == HALT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= START_ADDR;
            count_q  <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                bpc_q[i]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
                bpc_q[i]  <= bpc_d[i];
            end
        end
    end

    assign bus.mem_addr    = pc_q;
    assign bus.instr       = data_q[0];
    assign bus.instr_pc    = bpc_q[0];
    assign bus.instr_valid = valid_q;
    assign bus.halted      = halted_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the 256x8 instruction memory.
- Owns the 8-bit program counter and drives the memory address.
- Captures the combinationally-read instruction byte into a 2-entry prefetch buffer.
- Hands bytes to the decode stage over a valid/ready handshake; supports branch redirect/flush and halt-opcode detection.

Parameters:
- START_ADDR, 8'h00, PC value loaded on reset and used by start.
- HALT_OPCODE, 8'hFF, instruction byte that stops fetching.
- HALT_ENABLE, 1, 1 = halt-opcode detection active; 0 = never halt.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  begin fetching from START_ADDR (honoured in IDLE only)
- mem_addr  output  8  address to instruction memory; equals registered pc
- mem_data  input  8  instruction byte from memory, valid same cycle as mem_addr (combinational read)
- instr  output  8  head-of-buffer instruction byte
- instr_pc  output  8  address the head byte was fetched from
- instr_valid  output  1  buffer non-empty
- instr_ready  input  1  decode stage accepts head this cycle
- redirect  input  1  taken branch/jump: flush and reload pc
- redirect_addr  input  8  new pc when redirect=1
- halted  output  1  fetch stopped on halt opcode

Behaviour:
Reset (reset=1 at a rising edge):
- pc<=START_ADDR, state<=IDLE, count<=0, all buffer entries (byte and pc) <=0.
- Result: instr_valid=0, instr=0, instr_pc=0, halted=0, mem_addr=START_ADDR.
- Reset has priority over every other input, including mid-fetch and in HALT.

State machine (states IDLE, FETCH, HALT):
- IDLE -> FETCH on start=1. redirect is ignored in IDLE.
- FETCH -> HALT when the pushed byte equals HALT_OPCODE and HALT_ENABLE=1.
- FETCH or HALT -> FETCH on redirect=1.
- start is ignored in FETCH and HALT.
- halted = (state==HALT), registered.

Push:
- Occurs in FETCH when count<2, or count==2 with a pop in the same cycle.
- The buffer writes {mem_data, pc} at the tail, and pc<=pc+1.
- Otherwise pc holds and no memory byte is captured.
- The halt opcode is itself pushed so decode sees it. pc<=pc+1 on that push; no further pushes follow.

Pop:
- Occurs when instr_valid & instr_ready; the head entry is removed.
- A simultaneous push and pop leaves count unchanged and preserves order.

Buffer:
- FIFO, depth 2.
- instr_valid = (count!=0); instr and instr_pc come from the head entry.
- With count==0 the outputs hold the last popped values (or 0 after reset).

Wrap-around:
- pc increments modulo 256: 8'hFF -> 8'h00, no flag, fetch continues.

Redirect (highest priority after reset):
- count<=0 and pc<=redirect_addr; any push/pop that cycle is discarded.
- state<=FETCH, halted<=0.
- instr_valid=0 the next cycle.
- The first redirected byte is pushed the following cycle, so instr_valid=1 two cycles after redirect.

Latency:
- start asserted in cycle N:
  - cycle N+1: state=FETCH, mem_addr=START_ADDR.
  - end of N+1: push.
  - N+2: instr_valid=1, instr=mem[START_ADDR].
- Steady state with instr_ready=1 held: one byte per cycle.

Backpressure:
- With instr_ready=0 the buffer fills after 2 pushes.
- pc stops at first unfetched address, and mem_addr holds that value.

Test Plan:
1. Basic: memory 00:0x11, 01:0x22, 02:0x33; reset, start, instr_ready=1 -> instr_valid rises 2 cycles after start; instr sequence 0x11,0x22,0x33 with instr_pc 0,1,2 on consecutive cycles.
2. Backpressure: instr_ready=0 after start -> count reaches 2 (0x11,0x22), mem_addr holds 8'h02; raise instr_ready -> 0x11,0x22,0x33 in order, no loss/duplication.
3. Redirect: while fetching at pc=5 with 2 buffered, redirect=1, redirect_addr=8'h40 -> instr_valid=0 next cycle, then instr=mem[0x40], instr_pc=8'h40; flushed bytes never appear.
4. Halt: mem[03]=0xFF -> bytes 0..3 delivered including 0xFF, halted=1 one cycle after its push, mem_addr stays 8'h04; then redirect to 8'h10 -> halted=0, fetch resumes from 0x10.
5. Wrap: redirect_addr=8'hFE -> instr_pc sequence FE, FF, 00, 01.
6. Mid-run reset: assert reset during FETCH with count=2 -> next cycle instr_valid=0, halted=0, mem_addr=START_ADDR, state IDLE (no fetch until start).
